// File: rtl/fpu_cvt_from_int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_cvt_from_int_seq
//  Description : Multi-cycle FCVT.S.W / FCVT.S.WU converter. Takes a 32-bit
//                signed or unsigned integer and produces an IEEE-754 single.
//                Normalisation is an iterative left-shift loop with a coarse
//                step, followed by a single rounding cycle. Valid/ready
//                handshakes on both the operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_cvt_from_int_seq #(
  parameter int SHIFT_STEP = 4  // coarse normalise step; legal values 1, 2, 4, 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] int_i,
  input  logic        is_unsigned_i,
  input  logic [2:0]  rounding_mode_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        inexact_o
);

  // Exponent of a value whose leading one sits at bit 31 (127 + 31).
  localparam logic [7:0] c_EXP_TOP  = 8'd158;
  localparam logic [7:0] c_STEP_EXP = 8'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [2:0]  rm_q, rm_d;
  logic [31:0] result_q, result_d;
  logic        inexact_q, inexact_d;

  // Operand capture helpers: the negation of 0x80000000 wraps back to itself,
  // which is exactly the magnitude 2^31 we want.
  logic        w_sign_in;
  logic [31:0] w_mag_in;
  assign w_sign_in = ~is_unsigned_i & int_i[31];
  assign w_mag_in  = w_sign_in ? (~int_i + 32'd1) : int_i;

  // One normalise step: take the coarse shift only when it cannot push the
  // leading one off the top, otherwise creep by a single bit.
  logic        w_coarse_ok;
  logic [31:0] w_mag_shift;
  logic [7:0]  w_exp_shift;
  assign w_coarse_ok = (mag_q[31 -: SHIFT_STEP] == '0);
  assign w_mag_shift = w_coarse_ok ? (mag_q << SHIFT_STEP) : (mag_q << 1);
  assign w_exp_shift = w_coarse_ok ? (exp_q - c_STEP_EXP) : (exp_q - 8'd1);

  // Rounding: keep 24 significant bits (hidden one at bit 31, fraction in
  // [30:8]); bits [7:0] are discarded.
  logic        w_lsb, w_guard, w_round, w_sticky, w_nx, w_inc;
  logic [30:0] w_round_sum;
  assign w_lsb    = mag_q[8];
  assign w_guard  = mag_q[7];
  assign w_round  = mag_q[6];
  assign w_sticky = |mag_q[5:0];
  assign w_nx     = |mag_q[7:0];

  // Increment decision per rounding mode; reserved encodings truncate.
  always_comb begin
    w_inc = 1'b0;
    case (rm_q)
      3'b000:  w_inc = w_guard & (w_lsb | w_round | w_sticky);
      3'b010:  w_inc = sign_q & w_nx;
      3'b011:  w_inc = ~sign_q & w_nx;
      3'b100:  w_inc = w_guard;
      default: w_inc = 1'b0;
    endcase
  end

  // A mantissa carry ripples naturally into the exponent field.
  assign w_round_sum = {exp_q, mag_q[30:8]} + {30'd0, w_inc};

  // Next-state and datapath updates for the conversion sequence.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    rm_d      = rm_q;
    result_d  = result_q;
    inexact_d = inexact_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          rm_d   = rounding_mode_i;
          sign_d = w_sign_in;
          mag_d  = w_mag_in;
          exp_d  = c_EXP_TOP;
          if (w_mag_in == 32'd0) begin
            // Zero converts to +0 directly, skipping normalise and round.
            result_d  = 32'd0;
            inexact_d = 1'b0;
            state_d   = S_DONE;
          end else if (w_mag_in[31]) begin
            state_d = S_ROUND;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        mag_d = w_mag_shift;
        exp_d = w_exp_shift;
        if (w_mag_shift[31]) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d  = {sign_q, w_round_sum};
        inexact_d = w_nx;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      sign_q    <= 1'b0;
      rm_q      <= 3'd0;
      result_q  <= 32'd0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      rm_q      <= rm_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;
  assign inexact_o   = inexact_q;

endmodule
`default_nettype wire
